// File: rtl/sa_move_feeder_if.sv
// Load/start handshake from the array controller and the push stream into row 0 of a column.
interface sa_move_feeder_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 8
);
  logic                  clear;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  load_valid;
  logic                  load_last;
  logic                  load_ready;
  logic                  start;
  logic [CNT_WIDTH-1:0]  replay_cnt;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] move_buff_out;
  logic                  move_buff_out_valid;

  modport master (
    output clear, load_data, load_valid, load_last, start, replay_cnt,
    input  load_ready, busy, done, move_buff_out, move_buff_out_valid
  );

  modport slave (
    input  clear, load_data, load_valid, load_last, start, replay_cnt,
    output load_ready, busy, done, move_buff_out, move_buff_out_valid
  );
endinterface

// File: rtl/sa_move_feeder.sv
// Stages one word set and streams it (optionally replayed) into a spatial-array column.
// Define SA_FEED_REPLAY_EN to honour replay_cnt; otherwise every start sends one pass.
module sa_move_feeder #(
  parameter int DATA_WIDTH = 32,
  parameter int BUFF_DEPTH = 16,
  parameter int CNT_WIDTH  = 8
) (
  input  logic            clk,
  input  logic            rst,
  sa_move_feeder_if.slave f
);
  localparam int PW = $clog2(BUFF_DEPTH);
  localparam int LW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [PW-1:0] PTR_MAX = PW'(BUFF_DEPTH - 1);
  localparam logic [LW-1:0] LEN_ONE = LW'(1);

  typedef enum logic [1:0] {IDLE, LOADED, STREAM, DONE} state_t;

  state_t                state, state_nx;
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [LW-1:0]         set_len, last_idx;
  logic                  at_last, last_pass, stream_now;
  logic                  ld_we, ld_end, rd_start, rd_wrap, rd_inc;
  logic [DATA_WIDTH-1:0] mem [BUFF_DEPTH];
  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q, busy_q, done_q;

  assign last_idx   = set_len - LEN_ONE;
  assign at_last    = ({1'b0, rd_ptr} == last_idx);
  assign stream_now = (state == STREAM) && !f.clear;

`ifdef SA_FEED_REPLAY_EN
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  logic [CNT_WIDTH-1:0] pass, pass_max;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pass     <= '0;
      pass_max <= '0;
    end else if (f.clear) begin
      pass <= '0;
    end else if (rd_start) begin
      pass     <= '0;
      pass_max <= f.replay_cnt;
    end else if (rd_wrap) begin
      pass <= pass + CNT_ONE;
    end
  end

  assign last_pass = (pass == pass_max);
`else
  logic replay_unused;
  assign replay_unused = ^f.replay_cnt;
  assign last_pass     = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    ld_we    = 1'b0;
    ld_end   = 1'b0;
    rd_start = 1'b0;
    rd_wrap  = 1'b0;
    rd_inc   = 1'b0;
    if (f.clear) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (f.load_valid) begin
            ld_we = 1'b1;
            // A full buffer closes the set even without load_last.
            if (f.load_last || (wr_ptr == PTR_MAX)) begin
              ld_end   = 1'b1;
              state_nx = LOADED;
            end
          end
        end
        LOADED: begin
          if (f.start) begin
            rd_start = 1'b1;
            state_nx = STREAM;
          end
        end
        STREAM: begin
          if (at_last) begin
            if (last_pass) state_nx = DONE;
            else           rd_wrap  = 1'b1;
          end else begin
            rd_inc = 1'b1;
          end
        end
        DONE:    state_nx = LOADED;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      set_len <= '0;
    end else if (f.clear) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      set_len <= '0;
    end else begin
      if (ld_we)  wr_ptr  <= wr_ptr + PTR_ONE;
      if (ld_end) set_len <= {1'b0, wr_ptr} + LEN_ONE;
      if (rd_start || rd_wrap) rd_ptr <= '0;
      else if (rd_inc)         rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Staging buffer keeps its contents through reset; only pointers are cleared.
  always_ff @(posedge clk) begin
    if (ld_we) mem[wr_ptr] <= f.load_data;
  end

  // Output register stage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      data_q  <= stream_now ? mem[rd_ptr] : '0;
      valid_q <= stream_now;
      busy_q  <= (state_nx == STREAM);
      done_q  <= (state == DONE) && !f.clear;
    end
  end

  assign f.move_buff_out       = data_q;
  assign f.move_buff_out_valid = valid_q;
  assign f.busy                = busy_q;
  assign f.done                = done_q;
  assign f.load_ready          = (state == IDLE);
endmodule

// File: tb/tb_sa_move_feeder.sv
// Directed bench for sa_move_feeder with a word scoreboard fed at start and drained by a monitor.
`timescale 1ns/1ps
module tb_sa_move_feeder;
  localparam int DATA_WIDTH = 32;
  localparam int BUFF_DEPTH = 16;
  localparam int CNT_WIDTH  = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sa_move_feeder_if #(.DATA_WIDTH(DATA_WIDTH), .CNT_WIDTH(CNT_WIDTH)) f ();

  sa_move_feeder #(
    .DATA_WIDTH(DATA_WIDTH),
    .BUFF_DEPTH(BUFF_DEPTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .f  (f)
  );

  int n_cmp = 0;
  int n_err = 0;
  int run_len = 0;
  int last_burst = 0;
  int done_cnt = 0;
  logic [DATA_WIDTH-1:0] set_q [$];
  logic [DATA_WIDTH-1:0] exp_q [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int npass(input int rc);
`ifdef SA_FEED_REPLAY_EN
    return rc + 1;
`else
    return (rc < 0) ? 0 : 1;
`endif
  endfunction

  // Scoreboard drain: every valid word must match the next expected one.
  always @(negedge clk) begin
    if (f.move_buff_out_valid) begin
      run_len++;
      if (exp_q.size() == 0)
        chk("unexpected_valid", 64'(f.move_buff_out_valid), 64'(0));
      else
        chk("word", 64'(f.move_buff_out), 64'(exp_q.pop_front()));
    end else begin
      if (run_len != 0) last_burst = run_len;
      run_len = 0;
      chk("idle_data_zero", 64'(f.move_buff_out), 64'(0));
    end
    if (f.done) done_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [DATA_WIDTH-1:0] d, input logic last, input logic keep);
    f.load_data  = d;
    f.load_valid = 1'b1;
    f.load_last  = last;
    tick();
    f.load_valid = 1'b0;
    f.load_last  = 1'b0;
    f.load_data  = '0;
    if (keep) set_q.push_back(d);
  endtask

  task automatic push_expected(input int rc, output int tot);
    tot = set_q.size() * npass(rc);
    for (int p = 0; p < npass(rc); p++)
      foreach (set_q[i]) exp_q.push_back(set_q[i]);
  endtask

  task automatic do_stream(input string tag, input int rc, input bit mid_start);
    int tot, cyc, d0;
    push_expected(rc, tot);
    d0 = done_cnt;
    last_burst = 0;
    f.replay_cnt = CNT_WIDTH'(rc);
    f.start = 1'b1;
    tick();
    f.start = 1'b0;
    chk({tag, "_busy_rise"}, 64'(f.busy), 64'(1));
    chk({tag, "_no_word_yet"}, 64'(f.move_buff_out_valid), 64'(0));
    tick();
    chk({tag, "_word0_latency"}, 64'(f.move_buff_out_valid), 64'(1));
    cyc = 0;
    while (f.done !== 1'b1 && cyc < tot + 8) begin
      f.start = mid_start && (cyc == 1);
      tick();
      cyc++;
    end
    f.start = 1'b0;
    chk({tag, "_done_cycle"}, 64'(cyc), 64'(tot));
    chk({tag, "_busy_low_at_done"}, 64'(f.busy), 64'(0));
    chk({tag, "_valid_low_at_done"}, 64'(f.move_buff_out_valid), 64'(0));
    tick();
    chk({tag, "_done_one_cycle"}, 64'(f.done), 64'(0));
    chk({tag, "_burst_len"}, 64'(last_burst), 64'(tot));
    chk({tag, "_scoreboard_empty"}, 64'(exp_q.size()), 64'(0));
    chk({tag, "_done_count"}, 64'(done_cnt - d0), 64'(1));
    chk({tag, "_loaded_not_ready"}, 64'(f.load_ready), 64'(0));
  endtask

  initial begin
    int tot, d0;
    f.clear = 1'b0;
    f.load_data = '0;
    f.load_valid = 1'b0;
    f.load_last = 1'b0;
    f.start = 1'b0;
    f.replay_cnt = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 64'(f.move_buff_out_valid), 64'(0));
    chk("rst_data", 64'(f.move_buff_out), 64'(0));
    chk("rst_busy", 64'(f.busy), 64'(0));
    chk("rst_done", 64'(f.done), 64'(0));
    chk("rst_ready", 64'(f.load_ready), 64'(1));
    rst = 1'b1;
    tick();
    chk("ready_after_reset", 64'(f.load_ready), 64'(1));

    f.start = 1'b1;
    tick();
    f.start = 1'b0;
    tick();
    chk("idle_start_busy", 64'(f.busy), 64'(0));

    // Basic set; start pulsed with the last word must be ignored.
    load_word(32'h3F80_0000, 1'b0, 1'b1);
    load_word(32'h4000_0000, 1'b0, 1'b1);
    load_word(32'h4040_0000, 1'b0, 1'b1);
    f.start = 1'b1;
    load_word(32'h4080_0000, 1'b1, 1'b1);
    f.start = 1'b0;
    chk("loaded_ready_low", 64'(f.load_ready), 64'(0));
    tick();
    chk("start_with_last_busy", 64'(f.busy), 64'(0));
    chk("start_with_last_valid", 64'(f.move_buff_out_valid), 64'(0));

    do_stream("single", 0, 1'b0);
    do_stream("replay", 2, 1'b0);
    do_stream("midstart", 0, 1'b1);

    // Full buffer without load_last; the 17th word must be dropped.
    f.clear = 1'b1;
    tick();
    f.clear = 1'b0;
    set_q.delete();
    chk("clear_ready", 64'(f.load_ready), 64'(1));
    for (int i = 0; i < BUFF_DEPTH; i++) begin
      load_word(32'hA000_0000 + 32'(i * 7), 1'b0, 1'b1);
      if (i == BUFF_DEPTH - 2) chk("full_ready_before_last", 64'(f.load_ready), 64'(1));
    end
    chk("full_ready_low", 64'(f.load_ready), 64'(0));
    load_word(32'hDEAD_BEEF, 1'b1, 1'b0);
    do_stream("full", 1, 1'b0);

    // Clear on the 3rd valid cycle truncates the stream.
    push_expected(0, tot);
    d0 = done_cnt;
    f.start = 1'b1;
    tick();
    f.start = 1'b0;
    tick();
    tick();
    tick();
    chk("clr_third_valid", 64'(f.move_buff_out_valid), 64'(1));
    f.clear = 1'b1;
    tick();
    f.clear = 1'b0;
    chk("clr_valid_drop", 64'(f.move_buff_out_valid), 64'(0));
    chk("clr_busy_drop", 64'(f.busy), 64'(0));
    chk("clr_ready", 64'(f.load_ready), 64'(1));
    chk("clr_words_sent", 64'(exp_q.size()), 64'(tot - 3));
    exp_q.delete();
    set_q.delete();
    repeat (3) tick();
    chk("clr_no_done", 64'(done_cnt - d0), 64'(0));
    f.start = 1'b1;
    tick();
    f.start = 1'b0;
    repeat (4) tick();
    chk("clr_idle_start_busy", 64'(f.busy), 64'(0));
    chk("clr_idle_start_valid", 64'(f.move_buff_out_valid), 64'(0));

    // Asynchronous reset mid-stream.
    load_word(32'h0000_0011, 1'b0, 1'b1);
    load_word(32'h0000_0022, 1'b0, 1'b1);
    load_word(32'h0000_0033, 1'b0, 1'b1);
    load_word(32'h0000_0044, 1'b1, 1'b1);
    push_expected(0, tot);
    f.start = 1'b1;
    tick();
    f.start = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("arst_valid", 64'(f.move_buff_out_valid), 64'(0));
    chk("arst_data", 64'(f.move_buff_out), 64'(0));
    chk("arst_busy", 64'(f.busy), 64'(0));
    chk("arst_ready", 64'(f.load_ready), 64'(1));
    chk("arst_words_sent", 64'(exp_q.size()), 64'(tot - 1));
    exp_q.delete();
    set_q.delete();
    #2;
    rst = 1'b1;
    tick();
    chk("arst_ready_after", 64'(f.load_ready), 64'(1));
    d0 = done_cnt;
    f.start = 1'b1;
    tick();
    f.start = 1'b0;
    repeat (5) tick();
    chk("arst_start_busy", 64'(f.busy), 64'(0));
    chk("arst_start_valid", 64'(f.move_buff_out_valid), 64'(0));
    chk("arst_no_done", 64'(done_cnt - d0), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
